// File: rtl/fifo_pkg.sv
// Shared helpers for the multichannel FIFO: width calculations and the
// flat storage address used to map a channel's ring buffer into one SRAM.
`timescale 1ns/1ps

package fifo_pkg;

    // Width of a channel index; a single channel still gets a one-bit index.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Width of an occupancy counter that must be able to hold 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a ring pointer that walks 0..depth-1.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Each channel owns a contiguous block of depth words in the shared SRAM.
    function automatic int unsigned calc_addr(input int unsigned channel,
                                              input int unsigned ptr,
                                              input int unsigned depth);
        return channel * depth + ptr;
    endfunction

endpackage

// File: rtl/sram_dualport.sv
// Simple dual-port storage: one write port, one read port, registered read.
// A read and a write to the same address in one cycle return the old word.
`timescale 1ns/1ps

module sram_dualport #(
    parameter int WIDTH  = 10,
    parameter int WORDS  = 60,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    // Array write; contents are deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_multichannel.sv
// Multichannel FIFO: CHANNELS independent in-order queues sharing one SRAM.
// Pointers, counts, flags and error pulses live here; storage is external.
`timescale 1ns/1ps

module fifo_multichannel
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 15,
    parameter int CHANNELS  = 4,
    parameter int AFULL_THR = DEPTH - 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            wr_en_i,
    input  logic [ch_width(CHANNELS)-1:0]   wr_ch_i,
    input  logic [WIDTH-1:0]                data_i,
    input  logic                            rd_en_i,
    input  logic [ch_width(CHANNELS)-1:0]   rd_ch_i,
    output logic [WIDTH-1:0]                data_o,
    output logic                            rd_valid_o,
    output logic [ch_width(CHANNELS)-1:0]   rd_ch_o,
    output logic [CHANNELS-1:0]             empty_o,
    output logic [CHANNELS-1:0]             full_o,
    output logic [CHANNELS-1:0]             almost_full_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    localparam int CH_W   = ch_width(CHANNELS);
    localparam int CNT_W  = count_width(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int WORDS  = CHANNELS * DEPTH;
    localparam int ADDR_W = $clog2(WORDS);

    localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THR);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  wr_ptr     [CHANNELS];
    logic [PTR_W-1:0]  rd_ptr     [CHANNELS];
    logic [CNT_W-1:0]  count      [CHANNELS];
    logic [CNT_W-1:0]  count_next [CHANNELS];

    logic              wr_ch_ok;
    logic              rd_ch_ok;
    logic [CH_W-1:0]   wr_idx;
    logic [CH_W-1:0]   rd_idx;
    logic              wr_accept;
    logic              rd_accept;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] rd_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Ring pointer advance that wraps at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Request decode: range-check channels, then accept reads before writes so
    // a full channel can take a write when it is also being read this cycle.
    always_comb begin
        wr_ch_ok  = ({1'b0, wr_ch_i} < CH_LIMIT);
        rd_ch_ok  = ({1'b0, rd_ch_i} < CH_LIMIT);
        wr_idx    = wr_ch_ok ? wr_ch_i : '0;
        rd_idx    = rd_ch_ok ? rd_ch_i : '0;
        rd_accept = rd_en_i && rd_ch_ok && !empty_o[rd_idx];
        wr_accept = wr_en_i && wr_ch_ok &&
                    (!full_o[wr_idx] || (rd_accept && (rd_idx == wr_idx)));
        wr_sel    = '0;
        rd_sel    = '0;
        if (wr_accept) begin
            wr_sel[wr_idx] = 1'b1;
        end
        if (rd_accept) begin
            rd_sel[rd_idx] = 1'b1;
        end
        wr_addr = ADDR_W'(calc_addr(32'(wr_idx), 32'(wr_ptr[wr_idx]), DEPTH));
        rd_addr = ADDR_W'(calc_addr(32'(rd_idx), 32'(rd_ptr[rd_idx]), DEPTH));
    end

    // Next occupancy per channel; a simultaneous push and pop cancel out.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            count_next[c] = count[c];
            if (wr_sel[c] && !rd_sel[c]) begin
                count_next[c] = count[c] + CNT_W'(1);
            end else if (rd_sel[c] && !wr_sel[c]) begin
                count_next[c] = count[c] - CNT_W'(1);
            end
        end
    end

    // Write and read pointers advance only on accepted operations.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_sel[c]) begin
                    wr_ptr[c] <= bump(wr_ptr[c]);
                end
                if (rd_sel[c]) begin
                    rd_ptr[c] <= bump(rd_ptr[c]);
                end
            end
        end
    end

    // Occupancy counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c] <= count_next[c];
            end
        end
    end

    // Status flags are registered from the post-edge occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            empty_o       <= '1;
            full_o        <= '0;
            almost_full_o <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                empty_o[c]       <= (count_next[c] == '0);
                full_o[c]        <= (count_next[c] == FULL_CNT);
                almost_full_o[c] <= (count_next[c] >= AFULL_CNT);
            end
        end
    end

    // One-cycle error pulses for rejected requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= wr_en_i && !wr_accept;
            underflow_o <= rd_en_i && !rd_accept;
        end
    end

    // Read-side qualifiers line up with the SRAM's one-cycle read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_ch_o    <= '0;
        end else begin
            rd_valid_o <= rd_accept;
            if (rd_accept) begin
                rd_ch_o <= rd_idx;
            end
        end
    end

    sram_dualport #(
        .WIDTH  (WIDTH),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (data_i),
        .rd_en   (rd_accept),
        .rd_addr (rd_addr),
        .rd_data (data_o)
    );

endmodule

// File: tb/tb_fifo_multichannel.sv
// Scoreboard bench for fifo_multichannel: a queue-per-channel reference model
// predicts every cycle's flags and popped words; a monitor checks the DUT.
`timescale 1ns/1ps

module tb_fifo_multichannel;

    localparam int WIDTH     = 10;
    localparam int DEPTH     = 15;
    localparam int CHANNELS  = 4;
    localparam int AFULL_THR = DEPTH - 2;
    localparam int CH_W      = 2;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    logic                wr_en_i = 1'b0;
    logic [CH_W-1:0]     wr_ch_i = '0;
    logic [WIDTH-1:0]    data_i = '0;
    logic                rd_en_i = 1'b0;
    logic [CH_W-1:0]     rd_ch_i = '0;
    logic [WIDTH-1:0]    data_o;
    logic                rd_valid_o;
    logic [CH_W-1:0]     rd_ch_o;
    logic [CHANNELS-1:0] empty_o;
    logic [CHANNELS-1:0] full_o;
    logic [CHANNELS-1:0] almost_full_o;
    logic                overflow_o;
    logic                underflow_o;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } rd_item_t;

    typedef struct packed {
        logic                valid;
        logic [CHANNELS-1:0] empty;
        logic [CHANNELS-1:0] full;
        logic [CHANNELS-1:0] afull;
        logic                ovf;
        logic                unf;
    } status_t;

    rd_item_t         exp_rd_q [$];
    status_t          status_q [$];
    logic [WIDTH-1:0] model_q  [CHANNELS][$];

    int checks = 0;
    int errors = 0;

    status_t  mon_s;
    rd_item_t mon_item;

    int              writes_done;
    logic            rnd_we;
    logic            rnd_re;
    logic [CH_W-1:0] rnd_wc;
    logic [CH_W-1:0] rnd_rc;

    always #5 clk_i = ~clk_i;

    fifo_multichannel #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CHANNELS  (CHANNELS),
        .AFULL_THR (AFULL_THR)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .wr_ch_i       (wr_ch_i),
        .data_i        (data_i),
        .rd_en_i       (rd_en_i),
        .rd_ch_i       (rd_ch_i),
        .data_o        (data_o),
        .rd_valid_o    (rd_valid_o),
        .rd_ch_o       (rd_ch_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requests and record what the queue model predicts.
    task automatic applyStimulus(input logic wr_en, input logic [CH_W-1:0] wr_ch,
                                 input logic [WIDTH-1:0] data,
                                 input logic rd_en, input logic [CH_W-1:0] rd_ch);
        logic     rd_ok;
        logic     wr_ok;
        status_t  s;
        rd_item_t item;
        @(negedge clk_i);
        wr_en_i = wr_en;
        wr_ch_i = wr_ch;
        data_i  = data;
        rd_en_i = rd_en;
        rd_ch_i = rd_ch;
        rd_ok = rd_en && (int'(rd_ch) < CHANNELS) && (model_q[rd_ch].size() > 0);
        wr_ok = wr_en && (int'(wr_ch) < CHANNELS) &&
                ((model_q[wr_ch].size() < DEPTH) || (rd_ok && (rd_ch == wr_ch)));
        if (rd_ok) begin
            item.ch   = rd_ch;
            item.data = model_q[rd_ch].pop_front();
            exp_rd_q.push_back(item);
        end
        if (wr_ok) begin
            model_q[wr_ch].push_back(data);
        end
        s.valid = rd_ok;
        s.ovf   = wr_en && !wr_ok;
        s.unf   = rd_en && !rd_ok;
        for (int c = 0; c < CHANNELS; c++) begin
            s.empty[c] = (model_q[c].size() == 0);
            s.full[c]  = (model_q[c].size() == DEPTH);
            s.afull[c] = (model_q[c].size() >= AFULL_THR);
        end
        status_q.push_back(s);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Reset drops every stored word and every prediction still in flight.
    task automatic assertReset();
        rst_i   = 1'b1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        status_q.delete();
        exp_rd_q.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            model_q[c].delete();
        end
        #1;
        checkOutput("rst_empty",    32'(empty_o),       32'hF);
        checkOutput("rst_full",     32'(full_o),        32'h0);
        checkOutput("rst_afull",    32'(almost_full_o), 32'h0);
        checkOutput("rst_rd_valid", 32'(rd_valid_o),    32'h0);
        checkOutput("rst_overflow", 32'(overflow_o),    32'h0);
        checkOutput("rst_underflow",32'(underflow_o),   32'h0);
        checkOutput("rst_data",     32'(data_o),        32'h0);
        checkOutput("rst_rd_ch",    32'(rd_ch_o),       32'h0);
    endtask

    // Monitor: one prediction per driven cycle, one popped word per rd_valid_o.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                if (status_q.size() > 0) begin
                    mon_s = status_q.pop_front();
                    checkOutput("rd_valid",    32'(rd_valid_o),    32'(mon_s.valid));
                    checkOutput("empty",       32'(empty_o),       32'(mon_s.empty));
                    checkOutput("full",        32'(full_o),        32'(mon_s.full));
                    checkOutput("almost_full", 32'(almost_full_o), 32'(mon_s.afull));
                    checkOutput("overflow",    32'(overflow_o),    32'(mon_s.ovf));
                    checkOutput("underflow",   32'(underflow_o),   32'(mon_s.unf));
                end else if (rd_valid_o) begin
                    checkOutput("unexpected_valid", 32'(rd_valid_o), 32'h0);
                end
                if (rd_valid_o) begin
                    if (exp_rd_q.size() > 0) begin
                        mon_item = exp_rd_q.pop_front();
                        checkOutput("rd_data", 32'(data_o),  32'(mon_item.data));
                        checkOutput("rd_ch",   32'(rd_ch_o), 32'(mon_item.ch));
                    end else begin
                        checkOutput("spurious_read", 32'(rd_valid_o), 32'h0);
                    end
                end
            end
        end
    end

    // Watchdog so the run always reaches a verdict.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        assertReset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] fill channel 2 past full");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 2'd2, WIDTH'(i), 1'b0, '0);
        end

        $display("[TB] drain channel 2 past empty");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 2'd2);
        end

        $display("[TB] write and read a full channel 0 together");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 2'd0, WIDTH'(10'h100 + i), 1'b0, '0);
        end
        applyStimulus(1'b1, 2'd0, 10'h3FF, 1'b1, 2'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 2'd0);
        end

        $display("[TB] write ch1 while reading ch3");
        applyStimulus(1'b1, 2'd3, 10'h055, 1'b0, '0);
        applyStimulus(1'b1, 2'd1, 10'h2AA, 1'b1, 2'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 2'd1);

        $display("[TB] reset with channel 0 holding 7 words and a read in flight");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 2'd0, WIDTH'(10'h040 + i), 1'b0, '0);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 2'd0);
        #2;
        assertReset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 2'd0);
        idleCycle();

        $display("[TB] random traffic");
        writes_done = 0;
        while (writes_done < 1000) begin
            rnd_re = 1'($urandom_range(0, 1));
            rnd_rc = CH_W'($urandom_range(0, CHANNELS - 1));
            if (model_q[rnd_rc].size() == 0) rnd_re = 1'b0;
            rnd_we = 1'($urandom_range(0, 1));
            rnd_wc = CH_W'($urandom_range(0, CHANNELS - 1));
            if ((model_q[rnd_wc].size() >= DEPTH) && !(rnd_re && (rnd_rc == rnd_wc)))
                rnd_we = 1'b0;
            applyStimulus(rnd_we, rnd_wc, WIDTH'($urandom_range(0, 1023)), rnd_re, rnd_rc);
            if (rnd_we) writes_done++;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 10)) idleCycle();
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            while (model_q[c].size() > 0) begin
                applyStimulus(1'b0, '0, '0, 1'b1, CH_W'(c));
            end
        end

        idleCycle();
        idleCycle();
        @(posedge clk_i);
        #2;
        checkOutput("pending_status", 32'(status_q.size()), 32'h0);
        checkOutput("pending_reads",  32'(exp_rd_q.size()), 32'h0);
        checkOutput("final_empty",    32'(empty_o),         32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_multichannel.md
FIFO_MULTICHANNEL -- requirements
Module: fifo_multichannel

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 15, words per channel; any value >=2, not restricted to powers of two.
REQ-003 SHALL have parameter CHANNELS, default 4, number of independent logical FIFOs; any value >=1.
REQ-004 SHALL have parameter AFULL_THR, default DEPTH-2, occupancy at or above which almost_full_o asserts.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_en_i, input, 1, write request.
REQ-008 SHALL have port wr_ch_i, input, CH_W = max(1,$clog2(CHANNELS)), write channel.
REQ-009 SHALL have port data_i, input, WIDTH, write data.
REQ-010 SHALL have port rd_en_i, input, 1, read request.
REQ-011 SHALL have port rd_ch_i, input, CH_W, read channel.
REQ-012 SHALL have port data_o, output, WIDTH, read data.
REQ-013 SHALL have port rd_valid_o, output, 1, data_o carries a newly popped word.
REQ-014 SHALL have port rd_ch_o, output, CH_W, channel of the word on data_o.
REQ-015 SHALL have ports empty_o, full_o, almost_full_o, output, CHANNELS each, per-channel status bits.
REQ-016 SHALL have ports overflow_o, underflow_o, output, 1, single-cycle error pulses.

Function
REQ-017 Each channel SHALL be a strict in-order FIFO; channels SHALL NOT affect each other's contents or flags.
REQ-018 Write accepted iff wr_en_i and (channel not full, or a read of the same channel is accepted in the same cycle).
REQ-019 Read accepted iff rd_en_i and channel not empty; no write-to-read bypass: a write into an empty channel is readable from the next cycle.
REQ-020 Accepted read SHALL drive data_o, rd_ch_o and rd_valid_o=1 exactly one cycle later; otherwise rd_valid_o=0 and data_o holds its last value.
REQ-021 Rejected write SHALL pulse overflow_o for one cycle, storage and pointers unchanged.
REQ-022 Rejected read SHALL pulse underflow_o for one cycle, rd_valid_o=0 next cycle.
REQ-023 Per-channel write/read pointers SHALL wrap from DEPTH-1 to 0; storage address = channel*DEPTH + pointer.
REQ-024 Per-channel count SHALL be $clog2(DEPTH+1) bits: +1 on write only, -1 on read only, unchanged on both.
REQ-025 Flags SHALL be registered and reflect the count after the edge: empty = count 0, full = count DEPTH, almost_full = count >= AFULL_THR.
REQ-026 Simultaneous write and read to different channels SHALL both complete in one cycle.
REQ-027 Out-of-range channel index (>= CHANNELS) SHALL be treated as rejected and pulse the matching error output.

Reset
REQ-028 rst_i SHALL asynchronously clear all pointers and counts, set empty_o all-ones, full_o/almost_full_o/rd_valid_o/overflow_o/underflow_o to 0, data_o and rd_ch_o to 0.
REQ-029 Reset mid-operation SHALL discard all stored words and any in-flight read; storage contents need not be cleared.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the CH_W/count-width helper functions and the address-compute function.
REQ-031 Storage SHALL be sub-module sram_dualport: one write port, one read port, CHANNELS*DEPTH words, registered 1-cycle read.
REQ-032 Control (pointers, counts, flags, error pulses) SHALL be in fifo_multichannel, one always_ff per state group.

Verification
REQ-033 Fill ch2 with 15 words 1..15 -> full_o[2]=1 after 15th, 16th write pulses overflow_o; other channels empty_o=1.
REQ-034 Read ch2 15 times -> data_o 1..15 in order, each rd_valid_o=1, rd_ch_o=2, one cycle after rd_en_i; 16th read pulses underflow_o.
REQ-035 ch0 full, same-cycle write 0x3FF and read ch0 -> write accepted, count stays 15, no overflow; 0x3FF emerges last.
REQ-036 Write ch1 and read ch3 (holding 1 word) same cycle -> both complete, empty_o[3]=1, empty_o[1]=0 next cycle.
REQ-037 Assert rst_i mid-burst with ch0 holding 7 words -> empty_o=4'b1111, rd_valid_o=0 immediately; subsequent read pulses underflow_o.
REQ-038 Random valid/ready traffic on all 4 channels, 1000 words, random 0-10 cycle delays -> per-channel scoreboard matches, no spurious error pulses.
